// File: rtl/water_flow_monitor.sv
// Watches the tank level during fill/drain and raises a sticky fault after
// MAX_STRIKES consecutive windows without enough level change.
// Optional feature macro: WFM_REVERSE_FLOW_CHECK_EN (immediate fault on wrong-direction motion).
module water_flow_monitor #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int MIN_DELTA     = 4,
    parameter int MAX_STRIKES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       water_flow_reset,
    input  logic       water_flow_mode,
    input  logic [9:0] water_level_sensor,
    output logic       water_flow_error,
    output logic       monitor_active,
    output logic       flow_ok
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [15:0]        LAST_CNT = 16'(WINDOW_CYCLES - 1);
    localparam logic signed [10:0] MIN_D    = 11'(MIN_DELTA);
    localparam logic [3:0]         MAX_S    = 4'(MAX_STRIKES);

    state_t      state_q, state_d;
    logic [9:0]  baseline_q, baseline_d;
    logic        mode_q, mode_d;
    logic [15:0] window_cnt_q, window_cnt_d;
    logic [2:0]  strikes_q, strikes_d;
    logic        error_q, error_d;
    logic        active_q, active_d;
    logic        ok_q, ok_d;

    logic signed [10:0] sensor_s, baseline_s, fwd_delta;
    logic [3:0]         strike_next;
    logic               window_pass;

    // Delta is taken in the expected direction of travel; positive means progress.
    assign sensor_s    = $signed({1'b0, water_level_sensor});
    assign baseline_s  = $signed({1'b0, baseline_q});
    assign fwd_delta   = mode_q ? (sensor_s - baseline_s) : (baseline_s - sensor_s);
    assign strike_next = {1'b0, strikes_q} + 4'd1;
    assign window_pass = (fwd_delta >= MIN_D)
                       || (!mode_q && (water_level_sensor == 10'd0))
                       || ( mode_q && (water_level_sensor == 10'h3FF));

`ifdef WFM_REVERSE_FLOW_CHECK_EN
    logic signed [10:0] rev_delta;
    assign rev_delta = mode_q ? (baseline_s - sensor_s) : (sensor_s - baseline_s);
`endif

    always_comb begin
        state_d      = state_q;
        baseline_d   = baseline_q;
        mode_d       = mode_q;
        window_cnt_d = window_cnt_q;
        strikes_d    = strikes_q;
        error_d      = error_q;
        ok_d         = 1'b0;

        if (water_flow_reset) begin
            state_d      = IDLE;
            baseline_d   = 10'd0;
            mode_d       = 1'b0;
            window_cnt_d = 16'd0;
            strikes_d    = 3'd0;
            error_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    baseline_d   = water_level_sensor;
                    mode_d       = water_flow_mode;
                    window_cnt_d = 16'd0;
                    strikes_d    = 3'd0;
                    state_d      = MONITOR;
                end
                MONITOR: begin
                    // A direction change invalidates the current window entirely.
                    if (water_flow_mode != mode_q) begin
                        baseline_d   = water_level_sensor;
                        mode_d       = water_flow_mode;
                        window_cnt_d = 16'd0;
                        strikes_d    = 3'd0;
                    end
`ifdef WFM_REVERSE_FLOW_CHECK_EN
                    else if (rev_delta >= MIN_D) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
`endif
                    else if (window_cnt_q == LAST_CNT) begin
                        if (window_pass) begin
                            strikes_d    = 3'd0;
                            ok_d         = 1'b1;
                            baseline_d   = water_level_sensor;
                            window_cnt_d = 16'd0;
                        end else if (strike_next >= MAX_S) begin
                            state_d = ERROR;
                            error_d = 1'b1;
                        end else begin
                            strikes_d    = strike_next[2:0];
                            baseline_d   = water_level_sensor;
                            window_cnt_d = 16'd0;
                        end
                    end else begin
                        window_cnt_d = window_cnt_q + 16'd1;
                    end
                end
                ERROR: begin
                    error_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        active_d = (state_d == MONITOR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            baseline_q   <= 10'd0;
            mode_q       <= 1'b0;
            window_cnt_q <= 16'd0;
            strikes_q    <= 3'd0;
            error_q      <= 1'b0;
            active_q     <= 1'b0;
            ok_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            baseline_q   <= baseline_d;
            mode_q       <= mode_d;
            window_cnt_q <= window_cnt_d;
            strikes_q    <= strikes_d;
            error_q      <= error_d;
            active_q     <= active_d;
            ok_q         <= ok_d;
        end
    end

    assign water_flow_error = error_q;
    assign monitor_active   = active_q;
    assign flow_ok          = ok_q;

endmodule
